// File: rtl/issue_stage_pkg.sv
// Shared superscalar types: decode/EX slot payload, issue FSM states and small helpers.
// Used by issue_stage and issue_hazard_check.
package issue_stage_pkg;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  writeRegister;
        logic        regWrite;
        logic        memRead;
        logic [3:0]  ctrl;
        logic [31:0] opA;
        logic [31:0] opB;
        logic [31:0] pc;
    } slot_t;

    localparam int SLOT_W = $bits(slot_t);

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_SPLIT  = 2'b01
    } issue_state_t;

    // An invalid lane must never look like a register writer or a load downstream.
    function automatic slot_t lane_payload(input slot_t s, input logic valid);
        slot_t r;
        r          = s;
        r.regWrite = s.regWrite & valid;
        r.memRead  = s.memRead & valid;
        return r;
    endfunction

    // Register 0 is hardwired, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] wr, input logic [4:0] rs,
                                       input logic [4:0] rt);
        return (wr != 5'd0) && ((wr == rs) || (wr == rt));
    endfunction

endpackage

// File: rtl/issue_stage_hazard_check.sv
// Combinational hazard detection for the dual-issue stage: EX load-use and
// intra-bundle read-after-write between the two decode slots.
module issue_hazard_check
    import issue_stage_pkg::*;
(
    input  logic       split,
    input  logic       valid_d1,
    input  logic       valid_d2,
    input  logic [4:0] d1_rs,
    input  logic [4:0] d1_rt,
    input  logic [4:0] d1_wr,
    input  logic       d1_reg_write,
    input  logic [4:0] d2_rs,
    input  logic [4:0] d2_rt,
    input  logic       valid_e1,
    input  logic       valid_e2,
    input  logic [4:0] e1_wr,
    input  logic       e1_mem_read,
    input  logic [4:0] e2_wr,
    input  logic       e2_mem_read,
    output logic       load_use,
    output logic       intra_dep
);

    logic d1_pending;
    logic e1_load;
    logic e2_load;
    logic e1_hit;
    logic e2_hit;

    // While split, slot 1 has already left decode; only slot 2 is still waiting.
    assign d1_pending = valid_d1 && !split;
    assign e1_load    = valid_e1 && e1_mem_read;
    assign e2_load    = valid_e2 && e2_mem_read;

    assign e1_hit = (d1_pending && reg_match(e1_wr, d1_rs, d1_rt)) ||
                    (valid_d2 && reg_match(e1_wr, d2_rs, d2_rt));
    assign e2_hit = (d1_pending && reg_match(e2_wr, d1_rs, d1_rt)) ||
                    (valid_d2 && reg_match(e2_wr, d2_rs, d2_rt));

    assign load_use  = (e1_load && e1_hit) || (e2_load && e2_hit);
    assign intra_dep = valid_d1 && valid_d2 && d1_reg_write &&
                       reg_match(d1_wr, d2_rs, d2_rt);

endmodule

// File: rtl/issue_stage.sv
// Dual-issue decode-to-EX stage with load-use stalls and bundle splitting.
// Optional performance counters are built when ISSUE_PERF_CNT_EN is defined.
module issue_stage
    import issue_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [SLOT_W-1:0] slotD1,
    input  logic [SLOT_W-1:0] slotD2,
    input  logic              validD1,
    input  logic              validD2,
    input  logic              stallE,
    input  logic              flushE,
    output logic [SLOT_W-1:0] slotE1,
    output logic [SLOT_W-1:0] slotE2,
    output logic              validE1,
    output logic              validE2,
    output logic              stallD,
    output logic [31:0]       stallCount,
    output logic [31:0]       splitCount
);

    slot_t        slot_d1;
    slot_t        slot_d2;
    slot_t        slot_e1_q;
    slot_t        slot_e2_q;
    logic         valid_e1_q;
    logic         valid_e2_q;
    issue_state_t state_q;

    logic load_use;
    logic intra_dep;
    logic split_req;
    logic load_use_fire;
    logic split_fire;

    assign slot_d1 = slot_t'(slotD1);
    assign slot_d2 = slot_t'(slotD2);

    issue_hazard_check u_hazard (
        .split        (state_q == ST_SPLIT),
        .valid_d1     (validD1),
        .valid_d2     (validD2),
        .d1_rs        (slot_d1.rs),
        .d1_rt        (slot_d1.rt),
        .d1_wr        (slot_d1.writeRegister),
        .d1_reg_write (slot_d1.regWrite),
        .d2_rs        (slot_d2.rs),
        .d2_rt        (slot_d2.rt),
        .valid_e1     (valid_e1_q),
        .valid_e2     (valid_e2_q),
        .e1_wr        (slot_e1_q.writeRegister),
        .e1_mem_read  (slot_e1_q.memRead),
        .e2_wr        (slot_e2_q.writeRegister),
        .e2_mem_read  (slot_e2_q.memRead),
        .load_use     (load_use),
        .intra_dep    (intra_dep)
    );

    assign split_req     = (state_q == ST_NORMAL) && intra_dep;
    assign load_use_fire = !flushE && !stallE && load_use;
    assign split_fire    = !flushE && !stallE && !load_use && split_req;

    // Decode holds for backpressure, a load bubble, or the first half of a split; a flush overrides all.
    assign stallD = !flushE && (stallE || load_use || split_req);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_e1_q  <= '0;
            slot_e2_q  <= '0;
            valid_e1_q <= 1'b0;
            valid_e2_q <= 1'b0;
            state_q    <= ST_NORMAL;
        end else if (flushE) begin
            slot_e1_q  <= lane_payload(slot_e1_q, 1'b0);
            slot_e2_q  <= lane_payload(slot_e2_q, 1'b0);
            valid_e1_q <= 1'b0;
            valid_e2_q <= 1'b0;
            state_q    <= ST_NORMAL;
        end else if (!stallE) begin
            if (load_use) begin
                slot_e1_q  <= lane_payload(slot_e1_q, 1'b0);
                slot_e2_q  <= lane_payload(slot_e2_q, 1'b0);
                valid_e1_q <= 1'b0;
                valid_e2_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_NORMAL: begin
                        if (split_fire) begin
                            slot_e1_q  <= slot_d1;
                            slot_e2_q  <= lane_payload(slot_d2, 1'b0);
                            valid_e1_q <= 1'b1;
                            valid_e2_q <= 1'b0;
                            state_q    <= ST_SPLIT;
                        end else begin
                            slot_e1_q  <= lane_payload(slot_d1, validD1);
                            slot_e2_q  <= lane_payload(slot_d2, validD2);
                            valid_e1_q <= validD1;
                            valid_e2_q <= validD2;
                        end
                    end
                    // The dependent op goes to lane 1 so lane-1 M->E forwarding covers it.
                    ST_SPLIT: begin
                        slot_e1_q  <= lane_payload(slot_d2, validD2);
                        slot_e2_q  <= lane_payload(slot_e2_q, 1'b0);
                        valid_e1_q <= validD2;
                        valid_e2_q <= 1'b0;
                        state_q    <= ST_NORMAL;
                    end
                    default: begin
                        slot_e1_q  <= lane_payload(slot_e1_q, 1'b0);
                        slot_e2_q  <= lane_payload(slot_e2_q, 1'b0);
                        valid_e1_q <= 1'b0;
                        valid_e2_q <= 1'b0;
                        state_q    <= ST_NORMAL;
                    end
                endcase
            end
        end
    end

    assign slotE1  = slot_e1_q;
    assign slotE2  = slot_e2_q;
    assign validE1 = valid_e1_q;
    assign validE2 = valid_e2_q;

`ifdef ISSUE_PERF_CNT_EN
    logic [31:0] stall_count_q;
    logic [31:0] split_count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
            split_count_q <= '0;
        end else begin
            if (load_use_fire) stall_count_q <= stall_count_q + 32'd1;
            if (split_fire)    split_count_q <= split_count_q + 32'd1;
        end
    end

    assign stallCount = stall_count_q;
    assign splitCount = split_count_q;
`else
    logic unused_perf;
    assign unused_perf = load_use_fire;
    assign stallCount  = '0;
    assign splitCount  = '0;
`endif

endmodule
